// File: rtl/if_id_interlock.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_interlock
//  Purpose  : IF/ID pipeline register with its interlock controller. Freezes
//             the PC and IF/ID on a load-use stall and injects an ID/EX bubble.
//             It squashes the wrong-path fetch on a branch flush. A stall that
//             runs too long raises a sticky trap, which only reset can clear.
//  Ports    : clk, rst_n           clock, async active-low reset
//             stall_req            hazard detector stall request
//             flush                branch taken, resolved in ID
//             if_instr/if_pc_plus2/if_valid   fetch stage inputs
//             pc_we, idex_bubble   combinational interlock controls
//             id_instr/id_pc_plus2/id_valid   registered IF/ID contents
//             stall_cnt            consecutive stall cycles so far
//             stall_timeout        sticky runaway-stall trap flag
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_interlock #(
  parameter int             IW        = 16,
  parameter int             PW        = 16,
  parameter logic [IW-1:0]  NOP_INSTR = 16'h0000,
  parameter int             MAX_STALL = 3,
  localparam int            CW        = $clog2(MAX_STALL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_req,
  input  logic          flush,
  input  logic [IW-1:0] if_instr,
  input  logic [PW-1:0] if_pc_plus2,
  input  logic          if_valid,
  output logic          pc_we,
  output logic          idex_bubble,
  output logic [IW-1:0] id_instr,
  output logic [PW-1:0] id_pc_plus2,
  output logic          id_valid,
  output logic [CW-1:0] stall_cnt,
  output logic          stall_timeout
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] instr_d;
  logic [PW-1:0] pc_d;
  logic          valid_d;
  logic [CW-1:0] cnt_d;
  logic          timeout_d;
  logic          advance;
  logic          stall_eff;

  // A bubble in ID has no operands, so it cannot depend on a pending load.
  assign stall_eff   = stall_req & id_valid;
  assign pc_we       = (state != TRAP) & ~stall_eff;
  assign idex_bubble = (state == TRAP) | stall_eff;

  always_comb begin
    state_d   = state;
    instr_d   = id_instr;
    pc_d      = id_pc_plus2;
    valid_d   = id_valid;
    cnt_d     = stall_cnt;
    timeout_d = stall_timeout;
    advance   = 1'b0;

    case (state)
      RUN: begin
        if (stall_eff) begin
          cnt_d   = CW'(1);
          state_d = HOLD;
        end else begin
          advance = 1'b1;
        end
      end
      HOLD: begin
        if (stall_eff) begin
          if (stall_cnt == CW'(MAX_STALL)) begin
            // Counter stays saturated; the trap freezes everything.
            timeout_d = 1'b1;
            state_d   = TRAP;
          end else begin
            cnt_d = stall_cnt + CW'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = RUN;
          advance = 1'b1;
        end
      end
      default: begin
        // TRAP: nothing moves until reset.
      end
    endcase

    // A flush during a stall is dropped: ID re-asserts it once operands are valid.
    if (advance) begin
      if (flush) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        pc_d    = '0;
      end else begin
        instr_d = if_valid ? if_instr : NOP_INSTR;
        valid_d = if_valid;
        pc_d    = if_pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      id_instr      <= NOP_INSTR;
      id_pc_plus2   <= '0;
      id_valid      <= 1'b0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_d;
      id_instr      <= instr_d;
      id_pc_plus2   <= pc_d;
      id_valid      <= valid_d;
      stall_cnt     <= cnt_d;
      stall_timeout <= timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_interlock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_interlock
//  Purpose  : Directed self-checking bench for if_id_interlock. It covers
//             reset, single stall, flush, stall+flush, invalid fetch, the
//             timeout trap and reset in mid-stall.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_interlock;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_req = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] if_instr = '0;
  logic [15:0] if_pc_plus2 = '0;
  logic        if_valid = 1'b0;
  logic        pc_we;
  logic        idex_bubble;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus2;
  logic        id_valid;
  logic [1:0]  stall_cnt;
  logic        stall_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_interlock #(
    .IW(16), .PW(16), .NOP_INSTR(16'h0000), .MAX_STALL(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush(flush),
    .if_instr(if_instr), .if_pc_plus2(if_pc_plus2), .if_valid(if_valid),
    .pc_we(pc_we), .idex_bubble(idex_bubble), .id_instr(id_instr),
    .id_pc_plus2(id_pc_plus2), .id_valid(id_valid), .stall_cnt(stall_cnt),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ins, input logic [15:0] pc, input logic v);
    if_instr    = ins;
    if_pc_plus2 = pc;
    if_valid    = v;
  endtask

  initial begin
    // ---- asynchronous reset mid-cycle ----
    #3 rst_n = 1'b0;
    #1;
    check("rst_instr", 32'(id_instr), 32'h0000);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd1);
    check("rst_bubble", 32'(idex_bubble), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    check("rst_timeout", 32'(stall_timeout), 32'd0);
    tick();
    #2 rst_n = 1'b1;

    // ---- normal load ----
    fetch(16'h8123, 16'h0102, 1'b1);
    tick();
    check("load_instr", 32'(id_instr), 32'h8123);
    check("load_valid", 32'(id_valid), 32'd1);
    check("load_pc", 32'(id_pc_plus2), 32'h0102);

    // ---- single stall ----
    stall_req = 1'b1;
    fetch(16'h1456, 16'h0104, 1'b1);
    #1;
    check("stall_pc_we", 32'(pc_we), 32'd0);
    check("stall_bubble", 32'(idex_bubble), 32'd1);
    tick();
    check("stall_hold_instr", 32'(id_instr), 32'h8123);
    check("stall_cnt1", 32'(stall_cnt), 32'd1);
    stall_req = 1'b0;
    #1;
    check("unstall_pc_we", 32'(pc_we), 32'd1);
    tick();
    check("unstall_instr", 32'(id_instr), 32'h1456);
    check("unstall_pc", 32'(id_pc_plus2), 32'h0104);
    check("unstall_cnt", 32'(stall_cnt), 32'd0);

    // ---- flush, then stall against the bubble is ignored ----
    flush = 1'b1;
    fetch(16'h2ABC, 16'h0106, 1'b1);
    tick();
    check("flush_instr", 32'(id_instr), 32'h0000);
    check("flush_valid", 32'(id_valid), 32'd0);
    check("flush_pc", 32'(id_pc_plus2), 32'h0000);
    check("flush_pc_we", 32'(pc_we), 32'd1);
    flush = 1'b0;
    stall_req = 1'b1;
    fetch(16'h3333, 16'h0200, 1'b1);
    #1;
    check("ign_stall_pc_we", 32'(pc_we), 32'd1);
    check("ign_stall_bubble", 32'(idex_bubble), 32'd0);
    tick();
    check("ign_stall_instr", 32'(id_instr), 32'h3333);
    check("ign_stall_cnt", 32'(stall_cnt), 32'd0);

    // ---- stall + flush same cycle: stall wins ----
    flush = 1'b1;
    fetch(16'h4444, 16'h0202, 1'b1);
    #1;
    check("sf_pc_we", 32'(pc_we), 32'd0);
    tick();
    check("sf_hold_instr", 32'(id_instr), 32'h3333);
    check("sf_hold_valid", 32'(id_valid), 32'd1);
    check("sf_cnt", 32'(stall_cnt), 32'd1);
    stall_req = 1'b0;
    tick();
    check("sf_squash_instr", 32'(id_instr), 32'h0000);
    check("sf_squash_valid", 32'(id_valid), 32'd0);
    check("sf_squash_cnt", 32'(stall_cnt), 32'd0);
    flush = 1'b0;

    // ---- invalid fetch loads NOP ----
    fetch(16'h5555, 16'h0300, 1'b0);
    tick();
    check("inv_instr", 32'(id_instr), 32'h0000);
    check("inv_valid", 32'(id_valid), 32'd0);
    check("inv_pc", 32'(id_pc_plus2), 32'h0300);

    // ---- timeout trap ----
    fetch(16'h6001, 16'h0400, 1'b1);
    tick();
    check("to_load", 32'(id_instr), 32'h6001);
    stall_req = 1'b1;
    fetch(16'h6002, 16'h0402, 1'b1);
    tick();
    check("to_cnt1", 32'(stall_cnt), 32'd1);
    tick();
    check("to_cnt2", 32'(stall_cnt), 32'd2);
    tick();
    check("to_cnt3", 32'(stall_cnt), 32'd3);
    check("to_not_yet", 32'(stall_timeout), 32'd0);
    tick();
    check("to_flag", 32'(stall_timeout), 32'd1);
    check("to_cnt_sat", 32'(stall_cnt), 32'd3);
    check("to_pc_we", 32'(pc_we), 32'd0);
    stall_req = 1'b0;
    fetch(16'h7777, 16'h0500, 1'b1);
    tick();
    tick();
    check("trap_pc_we", 32'(pc_we), 32'd0);
    check("trap_bubble", 32'(idex_bubble), 32'd1);
    check("trap_instr", 32'(id_instr), 32'h6001);
    check("trap_flag", 32'(stall_timeout), 32'd1);

    // ---- reset out of TRAP ----
    #2 rst_n = 1'b0;
    #1;
    check("trap_rst_flag", 32'(stall_timeout), 32'd0);
    check("trap_rst_pc_we", 32'(pc_we), 32'd1);
    check("trap_rst_cnt", 32'(stall_cnt), 32'd0);
    #1 rst_n = 1'b1;

    // ---- reset mid-stall ----
    fetch(16'h8888, 16'h0600, 1'b1);
    tick();
    check("ms_load", 32'(id_instr), 32'h8888);
    stall_req = 1'b1;
    tick();
    tick();
    check("ms_cnt2", 32'(stall_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("ms_rst_cnt", 32'(stall_cnt), 32'd0);
    check("ms_rst_valid", 32'(id_valid), 32'd0);
    check("ms_rst_pc_we", 32'(pc_we), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    check("ms_after_instr", 32'(id_instr), 32'h8888);
    check("ms_after_cnt", 32'(stall_cnt), 32'd0);
    stall_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
